captura_resultado_red: RTL
==========================

Name: captura_resultado_red

Overview:
Control and capture stage directly upstream of the memory-mapped status/result read mux. It decodes host writes into start and clear commands, pulses the neural-network datapath to start, and waits for its done strobe with a timeout. It rescales and saturates the wide accumulator result to Width bits and holds the ready flag, sticky error flag and result value that the read mux presents at addresses 0x000, 0x001 and 0x004.

Parameters:
Width, 24, result/host data width (signed).
AccWidth, 48, NN accumulator width (signed).
FracBits, 10, fractional bits removed from accumulator (arithmetic right shift).
TimeoutCycles, 1023, max cycles in WAIT before timeout error.
TimeoutBits, 10, width of the timeout counter; must hold TimeoutCycles.

Ports:
Clk  in  1  system clock, all state on rising edge.
Reset  in  1  synchronous, active-high reset.
Write  in  1  host write strobe, one cycle per write.
Address  in  9  host word address.
WrDato  in  Width  host write data.
DoneRed  in  1  NN result-valid pulse.
AccDato  in  AccWidth  signed NN accumulator, valid while DoneRed=1.
OverflowRed  in  1  NN internal overflow, sampled with DoneRed.
StartRed  out  1  one-cycle start pulse to the NN.
Busy  out  1  high in START and WAIT.
ListoOut  out  1  result-ready flag (feeds read mux ListoIn).
ErrorOut  out  1  sticky error flag (feeds read mux InError).
DatoOut  out  Width  signed captured result (feeds read mux InDato).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all outputs 0, FSM=IDLE, timeout counter 0. Reset has priority over any other event in the same cycle, including mid-operation; a DoneRed arriving after an aborting reset is ignored in IDLE.
- Host commands, decoded only when Write=1:
  - 0x002 with WrDato[0]=1: start.
  - 0x000: clear ListoOut.
  - 0x004: clear ErrorOut.
  - Any other address: no effect.
- FSM states:
  - IDLE/DONE + start: ListoOut<=0, next=START. DatoOut holds its old value. ErrorOut is not cleared.
  - START: StartRed=1 for exactly this one cycle. Counter<=0. Next=WAIT.
  - WAIT + DoneRed=1: capture. Next=DONE.
  - WAIT + no DoneRed, counter==TimeoutCycles-1: DatoOut<=0, ErrorOut<=1, ListoOut<=1, next=DONE.
  - WAIT otherwise: counter+1.
  - DONE: holds outputs. Behaves as IDLE for commands.
- Start writes while Busy=1 are ignored.
- Latency:
  - Start write in cycle n: StartRed=1 in cycle n+1, WAIT from n+2.
  - DoneRed in cycle m: DatoOut, ListoOut=1 and any error update visible in cycle m+1.
- Capture arithmetic:
  - s = AccDato >>> FracBits (arithmetic shift, sign preserved).
  - s > 2^(Width-1)-1: DatoOut = 2^(Width-1)-1, ErrorOut<=1.
  - s < -2^(Width-1): DatoOut = -2^(Width-1), ErrorOut<=1.
  - Otherwise DatoOut = s[Width-1:0].
  - OverflowRed=1 with DoneRed also sets ErrorOut.
- ErrorOut is sticky: cleared only by reset or a write to 0x004. A set and a clear in the same cycle resolve to set.
- Clear-Listo write in the same cycle as a capture or timeout: ListoOut ends at 1 (completion wins).
- DoneRed outside WAIT is ignored and changes no output.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, StartRed never asserted.
- Write 0x002/1 at cycle n; DoneRed with AccDato=5120 (5.0 in Q10) at n+4 -> StartRed=1 only at n+1; Busy=1 n+1..n+4; at n+5 DatoOut=5, ListoOut=1, ErrorOut=0, Busy=0.
- AccDato=2^33 -> DatoOut=0x7FFFFF, ErrorOut=1. Then AccDato=-2^34 -> DatoOut=0x800000. Then write 0x004 -> ErrorOut=0 next cycle.
- With TimeoutCycles=16: start, never assert DoneRed -> 16 cycles after entering WAIT, ListoOut=1, ErrorOut=1, DatoOut=0, FSM in DONE.
- Start, then second 0x002 write while Busy -> exactly one StartRed pulse. Write 0x000 in the same cycle as DoneRed -> ListoOut=1.
- Start, then Reset asserted in WAIT, then DoneRed after reset -> all outputs 0, no capture.

Source files
------------

// File: rtl/captura_resultado_red.sv
// captura_resultado_red: host-command decode, NN start/wait control with timeout,
// and rescale/saturate capture of the accumulator into the ready/error/result
// registers presented by the status read mux.
module captura_resultado_red #(
   parameter int Width         = 24,
   parameter int AccWidth      = 48,
   parameter int FracBits      = 10,
   parameter int TimeoutCycles = 1023,
   parameter int TimeoutBits   = 10
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       Write,
   input  logic [8:0]                 Address,
   input  logic [Width-1:0]           WrDato,
   input  logic                       DoneRed,
   input  logic signed [AccWidth-1:0] AccDato,
   input  logic                       OverflowRed,
   output logic                       StartRed,
   output logic                       Busy,
   output logic                       ListoOut,
   output logic                       ErrorOut,
   output logic [Width-1:0]           DatoOut
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Saturation bounds expressed at accumulator width so the compare is signed and lossless.
   localparam logic signed [AccWidth-1:0] SAT_MAX =
      {{(AccWidth-Width+1){1'b0}}, {(Width-1){1'b1}}};
   localparam logic signed [AccWidth-1:0] SAT_MIN =
      {{(AccWidth-Width+1){1'b1}}, {(Width-1){1'b0}}};
   localparam logic [Width-1:0] DATO_MAX = {1'b0, {(Width-1){1'b1}}};
   localparam logic [Width-1:0] DATO_MIN = {1'b1, {(Width-1){1'b0}}};
   localparam logic [TimeoutBits-1:0] TIMEOUT_LAST = TimeoutBits'(TimeoutCycles - 1);

   state_t                      state_r;
   logic [TimeoutBits-1:0]      count_r;
   logic                        wr_start_s;
   logic                        clr_listo_s;
   logic                        clr_err_s;
   logic signed [AccWidth-1:0]  shifted_s;
   logic [Width-1:0]            sat_dato_s;
   logic                        sat_err_s;
   logic                        unused_wrdato_s;

   // Only bit 0 of the host data carries meaning (the start flag).
   assign unused_wrdato_s = ^WrDato[Width-1:1];

   // Host command decode; commands only exist while the write strobe is high.
   always_comb begin
      wr_start_s  = 1'b0;
      clr_listo_s = 1'b0;
      clr_err_s   = 1'b0;
      if (Write) begin
         wr_start_s  = (Address == 9'h002) && WrDato[0];
         clr_listo_s = (Address == 9'h000);
         clr_err_s   = (Address == 9'h004);
      end else begin
         wr_start_s  = 1'b0;
         clr_listo_s = 1'b0;
         clr_err_s   = 1'b0;
      end
   end

   // Drop fractional bits and clamp the result into the signed Width range.
   always_comb begin
      shifted_s  = AccDato >>> FracBits;
      sat_dato_s = shifted_s[Width-1:0];
      sat_err_s  = 1'b0;
      if (shifted_s > SAT_MAX) begin
         sat_dato_s = DATO_MAX;
         sat_err_s  = 1'b1;
      end else if (shifted_s < SAT_MIN) begin
         sat_dato_s = DATO_MIN;
         sat_err_s  = 1'b1;
      end else begin
         sat_dato_s = shifted_s[Width-1:0];
         sat_err_s  = 1'b0;
      end
   end

   // Control FSM with registered outputs; later assignments give completion priority over clears.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r  <= ST_IDLE;
         count_r  <= '0;
         StartRed <= 1'b0;
         Busy     <= 1'b0;
         ListoOut <= 1'b0;
         ErrorOut <= 1'b0;
         DatoOut  <= '0;
      end else begin
         StartRed <= 1'b0;
         if (clr_err_s) begin
            ErrorOut <= 1'b0;
         end
         if (clr_listo_s) begin
            ListoOut <= 1'b0;
         end
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (wr_start_s) begin
                  ListoOut <= 1'b0;
                  StartRed <= 1'b1;
                  Busy     <= 1'b1;
                  state_r  <= ST_START;
               end
            end
            ST_START: begin
               count_r <= '0;
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               if (DoneRed) begin
                  DatoOut  <= sat_dato_s;
                  ListoOut <= 1'b1;
                  if (sat_err_s || OverflowRed) begin
                     ErrorOut <= 1'b1;
                  end
                  Busy    <= 1'b0;
                  state_r <= ST_DONE;
               end else if (count_r == TIMEOUT_LAST) begin
                  DatoOut  <= '0;
                  ErrorOut <= 1'b1;
                  ListoOut <= 1'b1;
                  Busy     <= 1'b0;
                  state_r  <= ST_DONE;
               end else begin
                  count_r <= count_r + TimeoutBits'(1);
               end
            end
            default: begin
               Busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
